psum_writeback: RTL

Drains column-vector partial sums from the output FIFO and writes them to the psum SRAM, optionally read-modify-write accumulating them onto the value already stored at that address. Sits directly downstream of the corelet's ofifo and upstream of the psum SRAM / sfu read path. One `start` command moves `len` vectors into consecutive SRAM addresses beginning at `base_addr`.

---
 rtl/psum_writeback.sv | 123 ++++++++++++
 1 files changed

// File: rtl/psum_writeback.sv
// Moves column-vector partial sums from the ofifo into consecutive psum SRAM words,
// optionally read-modify-write accumulating onto the stored value with saturation.
module psum_writeback #(
   parameter int unsigned Col    = 8,
   parameter int unsigned PsumBw = 16,
   parameter int unsigned AddrBw = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  acc_en_i,
   input  logic [AddrBw-1:0]     base_addr_i,
   input  logic [AddrBw-1:0]     len_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  ofifo_valid_i,
   output logic                  ofifo_rd_o,
   input  logic [PsumBw*Col-1:0] psum_in_i,
   output logic                  sram_cen_o,
   output logic                  sram_wen_o,
   output logic [AddrBw-1:0]     sram_a_o,
   output logic [PsumBw*Col-1:0] sram_d_o,
   input  logic [PsumBw*Col-1:0] sram_q_i
);

   localparam int unsigned VecW = PsumBw * Col;

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic [AddrBw-1:0] addr_q, addr_d;
   logic [AddrBw-1:0] cnt_q, cnt_d;
   logic [AddrBw-1:0] len_q, len_d;
   logic              acc_q, acc_d;
   logic [AddrBw-1:0] cnt_inc;
   logic [VecW-1:0]   sum;

   function automatic logic [PsumBw-1:0] sat_add(input logic [PsumBw-1:0] a,
                                                 input logic [PsumBw-1:0] b);
      logic [PsumBw:0] s;
      s = {a[PsumBw-1], a} + {b[PsumBw-1], b};
      // On overflow the extra bit carries the true sign; clamp toward it.
      if (s[PsumBw] != s[PsumBw-1]) begin
         sat_add = {s[PsumBw], {(PsumBw-1){~s[PsumBw]}}};
      end else begin
         sat_add = s[PsumBw-1:0];
      end
   endfunction

   for (genvar i = 0; i < Col; i++) begin : g_lane
      assign sum[i*PsumBw +: PsumBw] = acc_q ?
                                       sat_add(psum_in_i[i*PsumBw +: PsumBw],
                                               sram_q_i[i*PsumBw +: PsumBw]) :
                                       psum_in_i[i*PsumBw +: PsumBw];
   end

   assign cnt_inc  = cnt_q + AddrBw'(1);
   assign sram_a_o = addr_q;
   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      acc_d      = acc_q;
      ofifo_rd_o = 1'b0;
      sram_cen_o = 1'b1;
      sram_wen_o = 1'b1;
      sram_d_o   = '0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               cnt_d   = '0;
               acc_d   = acc_en_i;
               len_d   = len_i;
               state_d = (len_i == '0) ? StDone : StRead;
            end
         end
         StRead: begin
            // The accumulate read lands on sram_q_i exactly when psum_in_i becomes valid.
            if (ofifo_valid_i) begin
               ofifo_rd_o = 1'b1;
               sram_cen_o = ~acc_q;
               state_d    = StWrite;
            end
         end
         StWrite: begin
            sram_cen_o = 1'b0;
            sram_wen_o = 1'b0;
            sram_d_o   = sum;
            addr_d     = addr_q + AddrBw'(1);
            cnt_d      = cnt_inc;
            state_d    = (cnt_inc == len_q) ? StDone : StRead;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         acc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
      end
   end

endmodule
